memoria_display: RTL and testbench

- Seven-segment code memory for the Nexys 3 DPWM display path.
- Takes one BCD/hex digit (0-15) from the digit multiplexer (Codificador_7_segmentos) and outputs the registered 8-bit segment pattern for the common-anode display.
- Provides an optional decimal point.
- Output is sampled once per CLK and held stable between updates.

---
 rtl/memoria_display_pkg.sv | 32 +++
 rtl/memoria_display_if.sv | 11 +
 rtl/memoria_display_rom.sv | 37 +++
 rtl/memoria_display.sv | 45 ++++
 tb/tb_memoria_display.sv | 127 ++++++++++++
 5 files changed

// File: rtl/memoria_display_pkg.sv
// rtl/memoria_display_pkg.sv - segment bit indices and active-high seven-segment glyphs
package memoria_display_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Bits are gfedcba, active high.
  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

endpackage

// File: rtl/memoria_display_if.sv
// rtl/memoria_display_if.sv - digit/decimal-point request and segment drive bundle
interface memoria_display_if;

  logic [3:0] numero;
  logic       punto;
  logic [7:0] controles_display;

  modport master (output numero, output punto, input controles_display);
  modport slave  (input numero, input punto, output controles_display);

endinterface

// File: rtl/memoria_display_rom.sv
// rtl/memoria_display_rom.sv - digit to glyph lookup; MEMORIA_DISPLAY_HEX_EN enables A-F glyphs
module memoria_display_rom
  import memoria_display_pkg::*;
(
  input  logic [3:0] numero,
  output logic [6:0] glyph,
  output logic       blank
);

  always_comb begin
    glyph = GLYPH_BLANK;
    blank = 1'b0;
    case (numero)
      4'd0:  glyph = GLYPH_0;
      4'd1:  glyph = GLYPH_1;
      4'd2:  glyph = GLYPH_2;
      4'd3:  glyph = GLYPH_3;
      4'd4:  glyph = GLYPH_4;
      4'd5:  glyph = GLYPH_5;
      4'd6:  glyph = GLYPH_6;
      4'd7:  glyph = GLYPH_7;
      4'd8:  glyph = GLYPH_8;
      4'd9:  glyph = GLYPH_9;
`ifdef MEMORIA_DISPLAY_HEX_EN
      4'd10: glyph = GLYPH_A;
      4'd11: glyph = GLYPH_B;
      4'd12: glyph = GLYPH_C;
      4'd13: glyph = GLYPH_D;
      4'd14: glyph = GLYPH_E;
      4'd15: glyph = GLYPH_F;
`endif
      // Without hex support, 10-15 blank the whole digit including dp.
      default: blank = 1'b1;
    endcase
  end

endmodule

// File: rtl/memoria_display.sv
// rtl/memoria_display.sv - registered seven-segment drive with dp and polarity; hex via MEMORIA_DISPLAY_HEX_EN
module memoria_display
  import memoria_display_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic               CLK,
  input  logic               RST,
  memoria_display_if.slave   disp
);

  localparam logic [7:0] SEG_OFF = {8{ACTIVE_LOW}};

  logic [6:0] glyph;
  logic       blank;
  logic [7:0] pattern_hi;
  logic [7:0] pattern;
  logic [7:0] controles_q;

  memoria_display_rom u_rom (
    .numero (disp.numero),
    .glyph  (glyph),
    .blank  (blank)
  );

  always_comb begin
    pattern_hi = 8'h00;
    if (!blank) begin
      pattern_hi[6:0]    = glyph;
      pattern_hi[SEG_DP] = disp.punto;
    end
    pattern = ACTIVE_LOW ? ~pattern_hi : pattern_hi;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      controles_q <= SEG_OFF;
    end else begin
      controles_q <= pattern;
    end
  end

  assign disp.controles_display = controles_q;

endmodule

// File: tb/tb_memoria_display.sv
// tb/tb_memoria_display.sv - scoreboard bench for both polarities; honours MEMORIA_DISPLAY_HEX_EN
module tb_memoria_display;

  logic CLK;
  logic RST;
  int   n_tests;
  int   n_fail;

  logic [7:0] exp_lo_q[$];
  logic [7:0] exp_hi_q[$];
  string      name_q[$];
  logic       stim_done;

  memoria_display_if if_lo ();
  memoria_display_if if_hi ();

  memoria_display #(.ACTIVE_LOW(1'b1)) dut_lo (
    .CLK  (CLK),
    .RST  (RST),
    .disp (if_lo.slave)
  );

  memoria_display #(.ACTIVE_LOW(1'b0)) dut_hi (
    .CLK  (CLK),
    .RST  (RST),
    .disp (if_hi.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Inputs change on the falling edge; the next rising edge samples them.
  task automatic apply(input logic rst, input logic [3:0] num, input logic pt,
                       input logic [7:0] exp_lo, input string name);
    @(negedge CLK);
    RST          = rst;
    if_lo.numero = num;
    if_lo.punto  = pt;
    if_hi.numero = num;
    if_hi.punto  = pt;
    exp_lo_q.push_back(exp_lo);
    exp_hi_q.push_back(~exp_lo);
    name_q.push_back(name);
  endtask

  always @(posedge CLK) begin
    #1;
    if (exp_lo_q.size() != 0) begin
      logic [7:0] e_lo;
      logic [7:0] e_hi;
      string      nm;
      e_lo = exp_lo_q.pop_front();
      e_hi = exp_hi_q.pop_front();
      nm   = name_q.pop_front();
      n_tests++;
      if (if_lo.controles_display !== e_lo) begin
        n_fail++;
        $display("FAIL %s active_low: got %h expected %h", nm, if_lo.controles_display, e_lo);
      end
      n_tests++;
      if (if_hi.controles_display !== e_hi) begin
        n_fail++;
        $display("FAIL %s active_high: got %h expected %h", nm, if_hi.controles_display, e_hi);
      end
    end
  end

  logic [7:0] dec_exp [10];
  logic [7:0] hex_exp [6];
  logic [7:0] a_dp_exp;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    stim_done = 1'b0;
    RST          = 1'b1;
    if_lo.numero = 4'd5;
    if_lo.punto  = 1'b0;
    if_hi.numero = 4'd5;
    if_hi.punto  = 1'b0;
    dec_exp = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
`ifdef MEMORIA_DISPLAY_HEX_EN
    hex_exp  = '{8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    a_dp_exp = 8'h08;
`else
    hex_exp  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    a_dp_exp = 8'hFF;
`endif

    apply(1'b1, 4'd5, 1'b0, 8'hFF, "reset_0");
    apply(1'b1, 4'd5, 1'b0, 8'hFF, "reset_1");
    apply(1'b0, 4'd5, 1'b0, 8'h92, "release");

    for (int i = 0; i < 10; i++)
      apply(1'b0, 4'(i), 1'b0, dec_exp[i], $sformatf("dec_%0d", i));

    apply(1'b0, 4'd1,  1'b1, 8'h79,    "dp_1");
    apply(1'b0, 4'd10, 1'b1, a_dp_exp, "dp_10");

    for (int i = 0; i < 6; i++)
      apply(1'b0, 4'(10 + i), 1'b0, hex_exp[i], $sformatf("hex_%0d", 10 + i));

    apply(1'b0, 4'd8, 1'b1, 8'h00, "eight_dp");
    apply(1'b0, 4'd8, 1'b1, 8'h00, "eight_dp_hold");

    apply(1'b0, 4'd3, 1'b0, 8'hB0, "mid_3a");
    apply(1'b0, 4'd7, 1'b0, 8'hF8, "mid_7a");
    apply(1'b1, 4'd3, 1'b0, 8'hFF, "mid_rst");
    apply(1'b0, 4'd7, 1'b0, 8'hF8, "mid_7b");
    apply(1'b0, 4'd3, 1'b0, 8'hB0, "mid_3b");

    apply(1'b1, 4'd8, 1'b1, 8'hFF, "final_reset");

    repeat (3) @(negedge CLK);
    n_tests++;
    if (exp_lo_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected outputs never checked, required 0", exp_lo_q.size());
    end
    stim_done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
